// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
//   loader_state_t : loader FSM states
//   BYTES_PER_WORD : bytes packed into one instruction word
//   BYTE_CNT_W     : width of the byte-within-word counter
//   WORD_W         : width of an assembled word
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } loader_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_W     = 2;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * 8;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer.
//   clk, rst          : clock, asynchronous active-high reset
//   load_i            : accept byte_i into the next byte lane
//   clear_i           : restart assembly at lane 0 (wins over load_i)
//   byte_i            : incoming byte
//   word_o            : assembly register with the current byte merged in when load_i is high
//   word_complete_o   : load_i is filling the last lane of the word
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_complete_o
);

  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0]     asm_q, asm_d;

  always_comb begin
    word_o = asm_q;
    if (load_i) begin
      word_o[{cnt_q, 3'b000} +: 8] = byte_i;
    end
    word_complete_o = load_i && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clear_i) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (load_i) begin
      // Counter wraps to 0 after the last lane.
      cnt_d = cnt_q + 1'b1;
      asm_d = word_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a byte program into instruction memory, holding the pipeline in reset meanwhile.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request a load (sampled only in IDLE)
//   word_count    : words to load, latched on an accepted start
//   byte_valid/byte_data/byte_ready : byte stream handshake
//   mem_wr_en/mem_wr_adr/mem_wr_data : instruction-memory write port
//   cpu_rst       : pipeline reset, high while loading
//   busy          : load in progress
//   done          : one-cycle pulse after the last word write
//   err           : sticky illegal-start flag, cleared by the next legal start
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned MAX_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_adr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] MaxCount = (ADDR_W + 1)'(MAX_WORDS);

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0] mem_wr_adr_q, mem_wr_adr_d;
  logic [WIDTH-1:0]  mem_wr_data_q, mem_wr_data_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              pk_load, pk_clear, pk_complete;
  logic [WORD_W-1:0] pk_word;
  logic              start_ok, last_word;

  assign pk_load   = (state_q == RECV) && byte_valid && byte_ready_q;
  assign start_ok  = (word_count != '0) && (word_count <= MaxCount);
  assign last_word = ({1'b0, idx_q} == (count_q - 1'b1));

  byte_packer u_packer (
    .clk             (clk),
    .rst             (rst),
    .load_i          (pk_load),
    .clear_i         (pk_clear),
    .byte_i          (byte_data),
    .word_o          (pk_word),
    .word_complete_o (pk_complete)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    idx_d         = idx_q;
    byte_ready_d  = byte_ready_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_adr_d  = mem_wr_adr_q;
    mem_wr_data_d = mem_wr_data_q;
    cpu_rst_d     = cpu_rst_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    pk_clear      = 1'b0;

    case (state_q)
      IDLE: begin
        cpu_rst_d = 1'b0;
        busy_d    = 1'b0;
        if (start) begin
          if (start_ok) begin
            count_d      = word_count;
            err_d        = 1'b0;
            busy_d       = 1'b1;
            cpu_rst_d    = 1'b1;
            byte_ready_d = 1'b1;
            idx_d        = '0;
            pk_clear     = 1'b1;
            state_d      = RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (pk_complete) begin
          byte_ready_d  = 1'b0;
          mem_wr_data_d = pk_word;
          mem_wr_adr_d  = idx_q;
          mem_wr_en_d   = 1'b1;
          state_d       = WRITE;
        end
      end
      WRITE: begin
        if (last_word) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d        = idx_q + 1'b1;
          pk_clear     = 1'b1;
          byte_ready_d = 1'b1;
          state_d      = RECV;
        end
      end
      DONE: begin
        busy_d    = 1'b0;
        cpu_rst_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      idx_q         <= '0;
      byte_ready_q  <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_adr_q  <= '0;
      mem_wr_data_q <= '0;
      cpu_rst_q     <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      byte_ready_q  <= byte_ready_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_adr_q  <= mem_wr_adr_d;
      mem_wr_data_q <= mem_wr_data_d;
      cpu_rst_q     <= cpu_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign byte_ready  = byte_ready_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_adr  = mem_wr_adr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the driver pushes expected writes, a negedge monitor
// pops and compares every mem_wr_en pulse.
module tb_program_loader;

  localparam int unsigned AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   word_count;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_adr;
  logic [31:0]   mem_wr_data;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  typedef struct {
    logic [AW-1:0] adr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            wr_cnt = 0;
  int            done_cnt = 0;
  logic [AW-1:0] last_adr = '0;

  program_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .word_count  (word_count),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_adr  (mem_wr_adr),
    .mem_wr_data (mem_wr_data),
    .cpu_rst     (cpu_rst),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare each write against the scoreboard, and check status in WRITE/DONE.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(mem_wr_adr), 64'hFFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_adr", 64'(mem_wr_adr), 64'(e.adr));
          chk("wr_data", 64'(mem_wr_data), 64'(e.data));
        end
        chk("ready_in_write", 64'(byte_ready), 64'd0);
        chk("cpu_rst_in_write", 64'(cpu_rst), 64'd1);
        wr_cnt++;
        last_adr = mem_wr_adr;
      end
      if (done) begin
        chk("done_status", {61'd0, byte_ready, cpu_rst, busy}, 64'b011);
        done_cnt++;
      end
    end
  end

  task automatic start_load(input logic [AW:0] cnt, input bit legal);
    @(negedge clk);
    start = 1'b1;
    word_count = cnt;
    @(negedge clk);
    start = 1'b0;
    if (legal) begin
      chk("start_status", {60'd0, busy, cpu_rst, err, byte_ready}, 64'b1101);
    end else begin
      chk("illegal_status", {61'd0, busy, cpu_rst, err}, 64'b001);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("byte_ready_timeout", 64'(n), 64'd0);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap == 0 ? 0 : 1 + (k % 3));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
    @(negedge clk);
    chk("after_done", {61'd0, busy, cpu_rst, done}, 64'b000);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.adr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int w0, d0;
    logic [31:0] w;
    rst = 1'b1;
    start = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data = '0;
    #1;
    chk("reset_outputs",
        {56'd0, byte_ready, mem_wr_en, cpu_rst, busy, done, err, 2'b00}, 64'b00100000);
    chk("reset_adr_data", {21'd0, mem_wr_adr, mem_wr_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("cpu_rst_release", 64'(cpu_rst), 64'd0);

    // Two-word load, back-to-back bytes.
    w0 = wr_cnt; d0 = done_cnt;
    push(11'd0, 32'h00500513);
    push(11'd1, 32'h00A00593);
    start_load(12'd2, 1'b1);
    send_word(32'h00500513, 0);
    send_word(32'h00A00593, 0);
    wait_done();
    chk("two_word_writes", 64'(wr_cnt - w0), 64'd2);
    chk("two_word_done", 64'(done_cnt - d0), 64'd1);

    // Same stream with 1-3 cycle gaps.
    w0 = wr_cnt;
    push(11'd0, 32'h00500513);
    push(11'd1, 32'h00A00593);
    start_load(12'd2, 1'b1);
    send_word(32'h00500513, 1);
    send_word(32'h00A00593, 1);
    wait_done();
    chk("gap_writes", 64'(wr_cnt - w0), 64'd2);

    // Illegal starts, then a legal one clears err.
    w0 = wr_cnt;
    start_load(12'd0, 1'b0);
    start_load(12'd2049, 1'b0);
    repeat (3) @(negedge clk);
    chk("illegal_no_writes", 64'(wr_cnt - w0), 64'd0);
    push(11'd0, 32'hDEADBEEF);
    start_load(12'd1, 1'b1);
    send_word(32'hDEADBEEF, 0);
    wait_done();

    // start during RECV is ignored (count stays 2, err stays 0).
    w0 = wr_cnt;
    push(11'd0, 32'h11223344);
    push(11'd1, 32'h55667788);
    start_load(12'd2, 1'b1);
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    start = 1'b1; word_count = 12'd1;
    @(negedge clk);
    start = 1'b0;
    start = 1'b1; word_count = 12'd0;
    @(negedge clk);
    start = 1'b0;
    chk("recv_start_err", 64'(err), 64'd0);
    send_byte(8'h22, 0);
    send_byte(8'h11, 0);
    send_word(32'h55667788, 0);
    wait_done();
    chk("recv_start_writes", 64'(wr_cnt - w0), 64'd2);

    // Reset after 6 bytes of a 3-word load.
    w0 = wr_cnt;
    push(11'd0, 32'hA1B2C3D4);
    start_load(12'd3, 1'b1);
    send_word(32'hA1B2C3D4, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        {56'd0, byte_ready, mem_wr_en, cpu_rst, busy, done, err, 2'b00}, 64'b00100000);
    chk("async_reset_adr_data", {21'd0, mem_wr_adr, mem_wr_data}, 64'd0);
    chk("async_reset_state", 64'(dut.state_q), 64'(loader_pkg::IDLE));
    chk("async_reset_bytecnt", 64'(dut.u_packer.cnt_q), 64'd0);
    @(negedge clk);
    chk("cpu_rst_held", 64'(cpu_rst), 64'd1);
    rst = 1'b0;
    chk("partial_writes", 64'(wr_cnt - w0), 64'd1);
    chk("partial_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("cpu_rst_release2", 64'(cpu_rst), 64'd0);
    push(11'd0, 32'hCAFEF00D);
    start_load(12'd1, 1'b1);
    send_word(32'hCAFEF00D, 0);
    wait_done();

    // Full-size load.
    w0 = wr_cnt; d0 = done_cnt;
    for (int i = 0; i < 2048; i++) begin
      w = {8'(i >> 3), 8'(i), 8'(i + 1), 8'hC0 ^ 8'(i)};
      push(11'(i), w);
    end
    start_load(12'd2048, 1'b1);
    for (int i = 0; i < 2048; i++) begin
      w = {8'(i >> 3), 8'(i), 8'(i + 1), 8'hC0 ^ 8'(i)};
      send_word(w, 0);
    end
    wait_done();
    chk("full_writes", 64'(wr_cnt - w0), 64'd2048);
    chk("full_last_adr", 64'(last_adr), 64'h7FF);
    chk("full_done", 64'(done_cnt - d0), 64'd1);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
